// File: rtl/gb_cpu_int_ctrl.sv
// Game Boy CPU interrupt controller: IF/IE registers, IME enable sequencing,
// and the RUN/HALT/DISPATCH core sequencer that selects the interrupt vector.
module gb_cpu_int_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_tick,
    input  logic        instr_end,
    input  logic        enable_interrupts,
    input  logic        disable_interrupts,
    input  logic        ime_set_now,
    input  logic        clear_interrupt_flag,
    input  logic        write_interrupt_vector,
    input  logic        halt_req,
    input  logic [4:0]  irq_in,
    input  logic        if_wr_en,
    input  logic [4:0]  if_wr_data,
    input  logic        ie_wr_en,
    input  logic [7:0]  ie_wr_data,
    output logic [4:0]  if_q,
    output logic [7:0]  ie_q,
    output logic        ime,
    output logic        halted,
    output logic        int_dispatch,
    output logic [15:0] int_vector
);

    typedef enum logic [1:0] {IME_OFF, IME_ARMED, IME_ON} ime_state_t;
    typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_DISPATCH} core_state_t;

    ime_state_t  ime_state, ime_next;
    core_state_t core_state, core_next;

    logic [4:0]  pending;
    logic [4:0]  if_next;
    logic [2:0]  idx, idx_next;
    logic        enter_dispatch;
    logic        clear_now;

    // Bit 0 (VBlank) has the highest priority.
    function automatic logic [2:0] lowest_set(input logic [4:0] p);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (p[i]) r = 3'(i);
        end
        return r;
    endfunction

    assign pending      = ie_q[4:0] & if_q;
    assign ime          = (ime_state == IME_ON);
    assign halted       = (core_state == ST_HALT);
    assign int_dispatch = (core_state == ST_DISPATCH);

    always_comb begin
        core_next = core_state;
        case (core_state)
            ST_RUN: begin
                if (m_tick && instr_end) begin
                    if (ime && (pending != 5'd0)) core_next = ST_DISPATCH;
                    else if (halt_req)            core_next = ST_HALT;
                end
            end
            ST_HALT: begin
                if (m_tick && (pending != 5'd0)) core_next = ime ? ST_DISPATCH : ST_RUN;
            end
            ST_DISPATCH: begin
                if (m_tick && write_interrupt_vector) core_next = ST_RUN;
            end
            default: core_next = ST_RUN;
        endcase
    end

    assign enter_dispatch = (core_next == ST_DISPATCH) && (core_state != ST_DISPATCH);
    assign idx_next       = enter_dispatch ? lowest_set(pending) : idx;

    // Dispatch entry overrides every IME control; DI beats RETI beats EI.
    always_comb begin
        ime_next = ime_state;
        if (m_tick) begin
            if (enter_dispatch)                                   ime_next = IME_OFF;
            else if (disable_interrupts)                          ime_next = IME_OFF;
            else if (ime_set_now)                                 ime_next = IME_ON;
            else if (ime_state == IME_ARMED)                      ime_next = IME_ON;
            else if (enable_interrupts && ime_state == IME_OFF)   ime_next = IME_ARMED;
        end
    end

    // Incoming requests are OR-ed last so a same-cycle write or clear never drops them.
    assign clear_now = clear_interrupt_flag && m_tick && (core_state == ST_DISPATCH);
    always_comb begin
        if_next = if_wr_en ? if_wr_data : if_q;
        if (clear_now) if_next = if_next & ~(5'b00001 << idx);
        if_next = if_next | irq_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_q       <= 5'd0;
            ie_q       <= 8'd0;
            ime_state  <= IME_OFF;
            core_state <= ST_RUN;
            idx        <= 3'd0;
            int_vector <= 16'h0040;
        end else begin
            if_q       <= if_next;
            if (ie_wr_en) ie_q <= ie_wr_data;
            ime_state  <= ime_next;
            core_state <= core_next;
            idx        <= idx_next;
            if (enter_dispatch) int_vector <= 16'h0040 + {10'd0, idx_next, 3'b000};
        end
    end

endmodule

// File: doc/gb_cpu_int_ctrl.md
GB_CPU_INT_CTRL -- requirements
Module: gb_cpu_int_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have: m_tick  in  1  M-cycle boundary strobe; state transitions only on clk edges with m_tick=1.
REQ-004 SHALL have: instr_end  in  1  high with m_tick on the last M-cycle of the current instruction.
REQ-005 SHALL have: enable_interrupts / disable_interrupts / ime_set_now  in  1 each  EI, DI and RETI controls from the current control-signal word.
REQ-006 SHALL have: clear_interrupt_flag / write_interrupt_vector  in  1 each  dispatch-sequence controls.
REQ-007 SHALL have: halt_req  in  1  HALT decoded in the current instruction.
REQ-008 SHALL have: irq_in  in  5  peripheral request pulses; bit0 VBlank .. bit4 Joypad.
REQ-009 SHALL have: if_wr_en in 1, if_wr_data in 5, ie_wr_en in 1, ie_wr_data in 8  CPU writes to 0xFF0F and 0xFFFF.
REQ-010 SHALL have: if_q out 5, ie_q out 8, ime out 1, halted out 1, int_dispatch out 1, int_vector out 16.

Function
REQ-011 SHALL hold IF (5 b) and IE (8 b); pending = IE[4:0] & IF; only IE[4:0] takes part in arbitration.
REQ-012 SHALL update IF every clk, independent of m_tick: next = (if_wr_en ? if_wr_data : IF), then clear the latched bit if clear_interrupt_flag & m_tick & state==DISPATCH, then OR irq_in.
REQ-013 SHALL let irq_in win over a clear or write to the same bit in the same cycle; no request is lost.
REQ-014 SHALL update IE on any clk with ie_wr_en=1.
REQ-015 SHALL implement IME FSM {IME_OFF, IME_ARMED, IME_ON}; ime=1 only in IME_ON.
REQ-016 IME, on m_tick: disable_interrupts -> OFF (highest priority); else ime_set_now -> ON; else enable_interrupts while OFF -> ARMED; ARMED -> ON on the next m_tick; EI while ARMED or ON -> no change.
REQ-017 Entering DISPATCH SHALL force IME_OFF; this overrides all other IME inputs that cycle.
REQ-018 SHALL implement core FSM {RUN, HALT, DISPATCH}; halted=1 only in HALT; int_dispatch=1 only in DISPATCH.
REQ-019 RUN, on m_tick & instr_end: if ime & pending!=0 -> DISPATCH; else if halt_req -> HALT; else stay RUN.
REQ-020 HALT, on m_tick: if pending!=0 and ime -> DISPATCH; if pending!=0 and !ime -> RUN (wake without dispatch); else stay HALT.
REQ-021 DISPATCH, on m_tick with write_interrupt_vector -> RUN; otherwise stay DISPATCH indefinitely.
REQ-022 On entry to DISPATCH SHALL latch idx = lowest set bit of pending (bit0 highest priority); idx is held until the next entry.
REQ-023 int_vector = 16'h0040 + 8*idx (0x0040, 0x0048, 0x0050, 0x0058, 0x0060); registered; changes only on DISPATCH entry.
REQ-024 clear_interrupt_flag SHALL clear only IF[idx], even if a higher-priority bit became pending after entry; it is ignored outside DISPATCH.
REQ-025 Pending evaluation SHALL use IF/IE as registered at the sampling edge; same-cycle writes affect the next m_tick.
REQ-026 ime in ARMED SHALL read as 0; an instruction ending on the same m_tick as ARMED->ON SHALL NOT dispatch.

Reset
REQ-027 rst_n=0 SHALL asynchronously force: IF=0, IE=0, IME_OFF, RUN, idx=0, ime=0, halted=0, int_dispatch=0, int_vector=16'h0040.
REQ-028 Reset asserted mid-DISPATCH or mid-HALT SHALL abandon the sequence; the first m_tick after release evaluates from RUN.

Verification
REQ-029 IE=0x1F, ime_set_now, irq_in=5'b00110, instr_end tick -> DISPATCH, int_vector=0x0048, ime=0; clear_interrupt_flag tick -> IF=5'b00100; write_interrupt_vector tick -> RUN.
REQ-030 EI on tick N with IE=0x01, IF=0x01, instr_end on ticks N+1 and N+2 -> no dispatch at N+1 (ARMED), DISPATCH at N+2 with vector 0x0040.
REQ-031 IME_OFF, halt_req+instr_end -> HALT; irq_in=5'b10000 with IE=0x10 -> next tick RUN, int_dispatch=0, IF=5'b10000.
REQ-032 In DISPATCH idx=2: irq_in[0] pulse and clear_interrupt_flag same tick -> IF[2]=0, IF[0]=1, vector remains 0x0050; irq_in[2] coincident with clear -> IF[2]=1.
REQ-033 EI+DI same tick -> IME_OFF; if_wr_en with 5'b11111 and irq_in=0 -> if_q=5'b11111; rst_n low while in DISPATCH -> all REQ-027 values immediately, without waiting for a clk edge.
